// File: rtl/gate_truth_table_checker.sv
// Sweeps the four (a,b) vectors onto a 2-input NAND/NOR block, samples after settling, scores results.
// Optional per-vector fail map is built only when GTC_FAILMAP_EN is defined.
module gate_truth_table_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       nand_in,
    input  logic       nor_in,
    output logic       dut_a,
    output logic       dut_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] first_fail,
    output logic [3:0] fail_map
);

    // state  | meaning
    // IDLE   | waiting for start, results held
    // SETTLE | vector driven, counting settle cycles
    // SAMPLE | compare gate outputs against golden values
    // DONE   | publish done/pass for one cycle
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    logic [1:0] state;
    logic [1:0] idx;
    logic [3:0] cnt;
    logic       exp_nand;
    logic       exp_nor;
    logic       mismatch;
    logic       accept;

    // Operands come straight from the idx flops, so they are registered and glitch-free.
    assign dut_a    = idx[1];
    assign dut_b    = idx[0];
    assign exp_nand = ~(idx[1] & idx[0]);
    assign exp_nor  = ~(idx[1] | idx[0]);
    assign mismatch = (nand_in != exp_nand) | (nor_in != exp_nor);
    assign accept   = (state == ST_IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= 2'd0;
            cnt        <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 3'd0;
            first_fail <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        idx        <= 2'd0;
                        cnt        <= 4'd0;
                        err_count  <= 3'd0;
                        first_fail <= 2'd0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == CNT_LAST) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (mismatch) begin
                        if (err_count != 3'd4) begin
                            err_count <= err_count + 3'd1;
                        end
                        if (err_count == 3'd0) begin
                            first_fail <= idx;
                        end
                    end
                    if (idx == 2'd3) begin
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + 2'd1;
                        cnt   <= 4'd0;
                        state <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= (err_count == 3'd0);
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef GTC_FAILMAP_EN
    logic [3:0] map_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            map_q <= 4'b0000;
        end else if (accept) begin
            map_q <= 4'b0000;
        end else if ((state == ST_SAMPLE) && mismatch) begin
            map_q[idx] <= 1'b1;
        end
    end

    assign fail_map = map_q;
`else
    assign fail_map = 4'b0000;
`endif

endmodule
